// File: rtl/bcd2bin_pkg.sv
// bcd2bin_pkg: shared constants, digit type and
// elaboration helpers for the streaming BCD converter.
package bcd2bin_pkg;

  localparam int BIT_PER_DIGIT = 4;

  // Wide enough for 10^n well past any sane digit count.
  localparam int POW_W = 256;

  typedef logic [BIT_PER_DIGIT-1:0] bcd_digit_t;

  function automatic logic [POW_W-1:0] pow10(
    input int n
  );
    logic [POW_W-1:0] p;
    p = 1;
    for (int i = 0; i < n; i++) begin
      p = p * 10;
    end
    return p;
  endfunction

  // ceil(log2(10^n)): growth of the accumulator per stage.
  function automatic int clog2_pow10(
    input int n
  );
    logic [POW_W-1:0] p;
    logic [POW_W-1:0] one;
    int g;
    p   = pow10(n);
    one = 1;
    g   = 0;
    for (int i = 0; i < POW_W; i++) begin
      if ((one << i) < p) begin
        g = i + 1;
      end
    end
    return g;
  endfunction

  function automatic int n_stages(
    input int nd,
    input int dps
  );
    return (nd + dps - 1) / dps;
  endfunction

endpackage

// File: rtl/bcd2bin_stage.sv
// bcd2bin_stage: one digit group's multiply-accumulate.
// Ports: acc_in (truncated running value), grp (group,
// MS digit on top), acc_out, ovf (bits above BIN_WIDTH),
// bad (some nibble > 9).
module bcd2bin_stage
  import bcd2bin_pkg::*;
#(
  parameter int DIGITS_PER_STAGE = 1,
  parameter int BIN_WIDTH        = 64
) (
  input  logic [BIN_WIDTH-1:0] acc_in,
  input  logic [BIT_PER_DIGIT*DIGITS_PER_STAGE-1:0] grp,
  output logic [BIN_WIDTH-1:0] acc_out,
  output logic                 ovf,
  output logic                 bad
);

  localparam int G = clog2_pow10(DIGITS_PER_STAGE);

  // Four spare bits so raw invalid nibbles (up to 15)
  // can never wrap the MAC and hide an overflow.
  localparam int AW = BIN_WIDTH + G + BIT_PER_DIGIT;

  logic [AW-1:0] mac;
  bcd_digit_t    d;

  // Horner form over the group gives
  // acc_in*10^D + sum(d_i*10^i) with only *10 steps.
  always_comb begin
    mac = AW'(acc_in);
    bad = 1'b0;
    d   = '0;
    for (int i = DIGITS_PER_STAGE - 1; i >= 0; i--) begin
      d   = grp[BIT_PER_DIGIT*i +: BIT_PER_DIGIT];
      mac = mac * AW'(10) + AW'(d);
      bad = bad | (d > 4'd9);
    end
  end

  assign acc_out = mac[BIN_WIDTH-1:0];
  assign ovf     = |mac[AW-1:BIN_WIDTH];

endmodule

// File: rtl/bcd2bin_stream.sv
// bcd2bin_stream: pipelined BCD to binary converter with
// valid/ready, tag sideband and sticky ovf/bad flags.
// Ports: i_clk, i_reset_n (async low); in: i_valid,
// o_ready, i_bcd, i_tag; out: o_valid, i_ready, o_bin,
// o_tag, o_overflow, o_bad_digit.
module bcd2bin_stream
  import bcd2bin_pkg::*;
#(
  parameter int N_DIGITS         = 20,
  parameter int DIGITS_PER_STAGE = 1,
  parameter int BIN_WIDTH        = 64,
  parameter int TAG_WIDTH        = 8
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [BIT_PER_DIGIT*N_DIGITS-1:0] i_bcd,
  input  logic [TAG_WIDTH-1:0]          i_tag,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [BIN_WIDTH-1:0]          o_bin,
  output logic [TAG_WIDTH-1:0]          o_tag,
  output logic                          o_overflow,
  output logic                          o_bad_digit
);

  localparam int NS =
    n_stages(N_DIGITS, DIGITS_PER_STAGE);
  localparam int GW = BIT_PER_DIGIT * DIGITS_PER_STAGE;
  localparam int PW = GW * NS;

  if (DIGITS_PER_STAGE < 1 ||
      DIGITS_PER_STAGE > N_DIGITS) begin : g_chk_dps
    $error("DIGITS_PER_STAGE must be 1..N_DIGITS");
  end
  if (BIN_WIDTH < 4) begin : g_chk_bw
    $error("BIN_WIDTH must be at least 4");
  end
  if (TAG_WIDTH < 1) begin : g_chk_tw
    $error("TAG_WIDTH must be at least 1");
  end

  // Stage registers
  logic                 v_q   [NS];
  logic [BIN_WIDTH-1:0] acc_q [NS];
  logic [TAG_WIDTH-1:0] tag_q [NS];
  logic                 ovf_q [NS];
  logic                 bad_q [NS];
  // Digits still to be consumed, next group on top.
  logic [PW-1:0]        rem_q [NS];

  // Per-stage inputs and next values
  logic                 v_in   [NS];
  logic [BIN_WIDTH-1:0] acc_in [NS];
  logic [TAG_WIDTH-1:0] tag_in [NS];
  logic                 ovf_in [NS];
  logic                 bad_in [NS];
  logic [PW-1:0]        src    [NS];
  logic [PW-1:0]        rem_d  [NS];
  logic [BIN_WIDTH-1:0] acc_d  [NS];
  logic                 ovf_g  [NS];
  logic                 bad_g  [NS];

  logic adv;

  // One global enable; a full output slot blocks
  // the whole pipe, bubbles included.
  assign adv     = ~v_q[NS-1] | i_ready;
  assign o_ready = adv;

  for (genvar s = 0; s < NS; s++) begin : g_stg
    if (s == 0) begin : g_head
      assign v_in[s]   = i_valid;
      assign acc_in[s] = '0;
      assign tag_in[s] = i_tag;
      assign ovf_in[s] = 1'b0;
      assign bad_in[s] = 1'b0;
      // Zero-extend: pad digits land at the MS end.
      assign src[s]    = PW'(i_bcd);
    end else begin : g_body
      assign v_in[s]   = v_q[s-1];
      assign acc_in[s] = acc_q[s-1];
      assign tag_in[s] = tag_q[s-1];
      assign ovf_in[s] = ovf_q[s-1];
      assign bad_in[s] = bad_q[s-1];
      assign src[s]    = rem_q[s-1];
    end

    assign rem_d[s] = src[s] << GW;

    bcd2bin_stage #(
      .DIGITS_PER_STAGE (DIGITS_PER_STAGE),
      .BIN_WIDTH        (BIN_WIDTH)
    ) u_stage (
      .acc_in  (acc_in[s]),
      .grp     (src[s][PW-1 -: GW]),
      .acc_out (acc_d[s]),
      .ovf     (ovf_g[s]),
      .bad     (bad_g[s])
    );
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int s = 0; s < NS; s++) begin
        v_q[s]   <= 1'b0;
        acc_q[s] <= '0;
        tag_q[s] <= '0;
        ovf_q[s] <= 1'b0;
        bad_q[s] <= 1'b0;
        rem_q[s] <= '0;
      end
    end else if (adv) begin
      for (int s = 0; s < NS; s++) begin
        v_q[s]   <= v_in[s];
        acc_q[s] <= acc_d[s];
        tag_q[s] <= tag_in[s];
        ovf_q[s] <= ovf_in[s] | ovf_g[s];
        bad_q[s] <= bad_in[s] | bad_g[s];
        rem_q[s] <= rem_d[s];
      end
    end
  end

  assign o_valid     = v_q[NS-1];
  assign o_bin       = acc_q[NS-1];
  assign o_tag       = tag_q[NS-1];
  assign o_overflow  = ovf_q[NS-1];
  assign o_bad_digit = bad_q[NS-1];

endmodule

// File: tb/tb_bcd2bin_stream.sv
// tb_bcd2bin_stream: two converters (1 and 3 digits per
// stage) against an exact-arithmetic scoreboard model.
`timescale 1ns/1ps
module tb_bcd2bin_stream;

  localparam int ND = 20;
  localparam int BW = 64;
  localparam int TW = 8;

  typedef struct {
    logic [63:0] bin;
    logic [7:0]  tag;
    logic        ovf;
    logic        bad;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lat_on = 0;
  int rnd_on = 0;
  int outstanding [2];

  logic        d_vld [2];
  logic [79:0] d_bcd [2];
  logic [7:0]  d_tag [2];
  logic        d_rdy [2];
  logic        o_vld [2];
  logic        o_rdy [2];
  logic [63:0] o_bin [2];
  logic [7:0]  o_tag [2];
  logic        o_ovf [2];
  logic        o_bad [2];

  logic [79:0] words [30];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(
    input string nm,
    input logic [127:0] act,
    input logic [127:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h",
               nm, act, exp);
    end
  endtask

  // Exact value: sum of digit*10^position, no stages.
  function automatic exp_t model(
    input logic [79:0] bcd,
    input logic [7:0]  tag
  );
    exp_t e;
    logic [127:0] v;
    logic [127:0] p;
    logic [3:0] d;
    v = '0;
    p = 128'd1;
    e.bad = 1'b0;
    for (int k = 0; k < ND; k++) begin
      d = bcd[4*k +: 4];
      v = v + 128'(d) * p;
      p = p * 10;
      if (d > 4'd9) e.bad = 1'b1;
    end
    e.bin = v[63:0];
    e.ovf = (v > 128'hFFFF_FFFF_FFFF_FFFF);
    e.tag = tag;
    e.cyc = 0;
    return e;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int DPS = (g == 0) ? 1 : 3;
    localparam int NS  = (ND + DPS - 1) / DPS;

    exp_t        q [$];
    logic        stall_q = 1'b0;
    logic [63:0] p_bin;
    logic [7:0]  p_tag;
    logic        p_ovf;
    logic        p_bad;

    bcd2bin_stream #(
      .N_DIGITS         (ND),
      .DIGITS_PER_STAGE (DPS),
      .BIN_WIDTH        (BW),
      .TAG_WIDTH        (TW)
    ) u_dut (
      .i_clk       (clk),
      .i_reset_n   (rst_n),
      .i_valid     (d_vld[g]),
      .o_ready     (o_rdy[g]),
      .i_bcd       (d_bcd[g]),
      .i_tag       (d_tag[g]),
      .o_valid     (o_vld[g]),
      .i_ready     (d_rdy[g]),
      .o_bin       (o_bin[g]),
      .o_tag       (o_tag[g]),
      .o_overflow  (o_ovf[g]),
      .o_bad_digit (o_bad[g])
    );

    always @(negedge rst_n) begin
      q.delete();
      stall_q = 1'b0;
      outstanding[g] = 0;
    end

    always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
        if (stall_q) begin
          check($sformatf("hold_vld%0d", g), 128'(o_vld[g]), 128'd1);
          check($sformatf("hold_bin%0d", g), 128'(o_bin[g]), 128'(p_bin));
          check($sformatf("hold_tag%0d", g), 128'(o_tag[g]), 128'(p_tag));
          check($sformatf("hold_flg%0d", g),
                128'({o_ovf[g], o_bad[g]}), 128'({p_ovf, p_bad}));
        end
        if (o_vld[g] && d_rdy[g]) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious%0d: got output tag 0x%0h, required none",
                     g, o_tag[g]);
          end else begin
            e = q.pop_front();
            check($sformatf("bin%0d", g), 128'(o_bin[g]), 128'(e.bin));
            check($sformatf("tag%0d", g), 128'(o_tag[g]), 128'(e.tag));
            check($sformatf("ovf%0d", g), 128'(o_ovf[g]), 128'(e.ovf));
            check($sformatf("bad%0d", g), 128'(o_bad[g]), 128'(e.bad));
            if (lat_on != 0) begin
              check($sformatf("latency%0d", g),
                    128'(cyc - e.cyc), 128'(NS));
            end
          end
        end
        if (d_vld[g] && o_rdy[g]) begin
          e = model(d_bcd[g], d_tag[g]);
          e.cyc = cyc;
          q.push_back(e);
        end
        stall_q = o_vld[g] && !d_rdy[g];
        p_bin = o_bin[g];
        p_tag = o_tag[g];
        p_ovf = o_ovf[g];
        p_bad = o_bad[g];
        outstanding[g] = q.size();
      end
    end
  end

  task automatic send(
    input int g,
    input logic [79:0] bcd,
    input logic [7:0] tag
  );
    bit ok;
    int n;
    d_vld[g] = 1'b1;
    d_bcd[g] = bcd;
    d_tag[g] = tag;
    n = 0;
    do begin
      @(negedge clk);
      ok = o_rdy[g];
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 500);
    d_vld[g] = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout%0d: got no accept, required accept", g);
    end
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((outstanding[0] != 0 || outstanding[1] != 0)
           && n < limit) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (outstanding[0] != 0 || outstanding[1] != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending, required 0/0",
               outstanding[0], outstanding[1]);
    end
  endtask

  task automatic reset_checks;
    for (int g = 0; g < 2; g++) begin
      check($sformatf("rst_vld%0d", g), 128'(o_vld[g]), 128'd0);
      check($sformatf("rst_bin%0d", g), 128'(o_bin[g]), 128'd0);
      check($sformatf("rst_tag%0d", g), 128'(o_tag[g]), 128'd0);
      check($sformatf("rst_flg%0d", g),
            128'({o_ovf[g], o_bad[g]}), 128'd0);
      check($sformatf("rst_rdy%0d", g), 128'(o_rdy[g]), 128'd1);
    end
  endtask

  initial begin
    d_rdy[0] = 1'b1;
    d_rdy[1] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) begin
        d_rdy[g] = (rnd_on != 0) ?
                   1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t m;
    for (int g = 0; g < 2; g++) begin
      d_vld[g] = 1'b0;
      d_bcd[g] = '0;
      d_tag[g] = '0;
      outstanding[g] = 0;
    end

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_checks();
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Pin the model with hand-computed values
    m = model(80'h12345, 8'h5A);
    check("pin_12345", 128'(m.bin), 128'd12345);
    check("pin_12345_flags", 128'({m.ovf, m.bad}), 128'd0);
    m = model(80'h18446744073709551615, 8'h00);
    check("pin_max", 128'(m.bin), 128'hFFFF_FFFF_FFFF_FFFF);
    check("pin_max_ovf", 128'(m.ovf), 128'd0);
    m = model(80'h18446744073709551616, 8'h00);
    check("pin_wrap", 128'(m.bin), 128'd0);
    check("pin_wrap_ovf", 128'(m.ovf), 128'd1);
    m = model(80'h99999999999999999999, 8'h00);
    check("pin_nines", 128'(m.bin), 128'h6BC75E2D630FFFFF);
    check("pin_nines_flags", 128'({m.ovf, m.bad}), 128'b10);
    m = model(80'hA000, 8'h00);
    check("pin_bad", 128'(m.bin), 128'd10000);
    check("pin_bad_flags", 128'({m.ovf, m.bad}), 128'b01);

    // Directed vectors, no stall, latency checked
    lat_on = 1;
    fork
      for (int g = 0; g < 2; g++) begin
        automatic int gg = g;
        fork
          begin
            send(gg, 80'h12345, 8'h5A);
            send(gg, 80'h18446744073709551615, 8'h01);
            send(gg, 80'h18446744073709551616, 8'h02);
            send(gg, 80'h99999999999999999999, 8'h03);
            send(gg, 80'hA000, 8'h04);
          end
        join_none
      end
    join
    wait fork;
    drain(200);
    lat_on = 0;

    // Back-to-back words with random downstream stalls
    for (int i = 0; i < 30; i++) begin
      logic [79:0] w;
      for (int k = 0; k < 20; k++) begin
        w[4*k +: 4] = 4'($urandom_range(0, 9));
      end
      if (i % 7 == 3) begin
        w[4*(i % 20) +: 4] = 4'($urandom_range(10, 15));
      end
      if (i == 10) w = 80'h99999999999999999999;
      words[i] = w;
    end
    rnd_on = 1;
    fork
      begin
        for (int i = 0; i < 30; i++) send(0, words[i], 8'(i));
      end
      begin
        for (int i = 0; i < 30; i++) send(1, words[i], 8'(i + 64));
      end
    join
    drain(2000);
    rnd_on = 0;
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-stream
    fork
      begin
        for (int i = 0; i < 5; i++) send(0, words[i], 8'(i + 128));
      end
      begin
        for (int i = 0; i < 5; i++) send(1, words[i], 8'(i + 192));
      end
    join
    repeat (4) @(posedge clk);
    #2;
    check("pre_rst_vld1", 128'(o_vld[1]), 128'd1);
    rst_n = 1'b0;
    #1;
    check("async_vld0", 128'(o_vld[0]), 128'd0);
    check("async_vld1", 128'(o_vld[1]), 128'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("post_rst_rdy0", 128'(o_rdy[0]), 128'd1);
    check("post_rst_rdy1", 128'(o_rdy[1]), 128'd1);
    repeat (30) @(posedge clk);
    #1;
    fork
      send(0, 80'h12345, 8'h77);
      send(1, 80'h12345, 8'h78);
    join
    drain(200);

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
